led_pattern_sequencer: RTL and testbench



---
 rtl/led_pattern_sequencer.sv | 174 +++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Steps the board LEDs through COUNT/SCAN/BLINK/SHIFT patterns at a programmable
// rate, with mode changes deferred to a step boundary and PWM brightness gating.
module led_pattern_sequencer #(
    parameter int STEP_PERIOD_CYCLES = 5000000,
    parameter int LED_WIDTH          = 8,
    parameter int PWM_BITS           = 4
) (
    input  logic                 clk_40mhz,
    input  logic                 rst_n,
    input  logic                 mode_valid,
    output logic                 mode_ready,
    input  logic [1:0]           mode,
    input  logic [PWM_BITS-1:0]  brightness,
    input  logic                 pause,
    output logic                 step_strobe,
    output logic [LED_WIDTH-1:0] led
);

    localparam int                   PRE_W    = $clog2(STEP_PERIOD_CYCLES);
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(STEP_PERIOD_CYCLES - 1);
    localparam logic [LED_WIDTH-1:0] LSB_ONE  = LED_WIDTH'(1);
    localparam logic [LED_WIDTH-1:0] MSB_ONE  = LSB_ONE << (LED_WIDTH - 1);
    localparam logic [LED_WIDTH-1:0] ALL_ON   = '1;
    localparam logic [LED_WIDTH-1:0] ALL_OFF  = '0;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_SHIFT = 2'd3
    } mode_t;

    typedef enum logic {
        ST_RUN,
        ST_PENDING
    } state_t;

    state_t               state;
    state_t               state_next;
    mode_t                cur_mode;
    mode_t                pending_mode;
    logic [PRE_W-1:0]     prescaler;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [LED_WIDTH-1:0] pattern;
    logic [LED_WIDTH-1:0] pattern_next;
    logic                 scan_up;
    logic                 scan_up_next;
    logic                 wrap;
    logic                 accept;
    logic                 load;
    logic                 gate;

    function automatic logic [LED_WIDTH-1:0] init_pattern(input mode_t m);
        logic [LED_WIDTH-1:0] p;
        p = ALL_OFF;
        case (m)
            MODE_COUNT: p = ALL_OFF;
            MODE_SCAN:  p = LSB_ONE;
            MODE_BLINK: p = ALL_ON;
            MODE_SHIFT: p = LSB_ONE;
            default:    p = ALL_OFF;
        endcase
        return p;
    endfunction

    // Returns {scan direction, next pattern}; direction only changes in SCAN.
    function automatic logic [LED_WIDTH:0] advance(input mode_t m,
                                                   input logic [LED_WIDTH-1:0] p,
                                                   input logic up);
        logic [LED_WIDTH-1:0] n;
        logic                 d;
        n = p;
        d = up;
        case (m)
            MODE_COUNT: n = p + LSB_ONE;
            MODE_SCAN: begin
                if (up) begin
                    if (p == MSB_ONE) begin
                        d = 1'b0;
                        n = p >> 1;
                    end else begin
                        n = p << 1;
                    end
                end else begin
                    if (p == LSB_ONE) begin
                        d = 1'b1;
                        n = p << 1;
                    end else begin
                        n = p >> 1;
                    end
                end
            end
            MODE_BLINK: n = (p == ALL_ON) ? ALL_OFF : ALL_ON;
            MODE_SHIFT: n = {p[LED_WIDTH-2:0], p[LED_WIDTH-1]};
            default:    n = p;
        endcase
        return {d, n};
    endfunction

    assign wrap   = !pause && (prescaler == PRE_LAST);
    assign accept = mode_valid && mode_ready;
    assign load   = wrap && (state == ST_PENDING);
    assign gate   = (brightness == '1) || (pwm_cnt < brightness);

    always_ff @(posedge clk_40mhz) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A wrap in the accept cycle still sees ST_RUN, so it advances the old mode.
    always_comb begin
        state_next = state;
        mode_ready = 1'b0;
        case (state)
            ST_RUN: begin
                mode_ready = 1'b1;
                if (mode_valid) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (wrap) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        pattern_next = pattern;
        scan_up_next = scan_up;
        if (load) begin
            pattern_next = init_pattern(pending_mode);
            scan_up_next = 1'b1;
        end else if (wrap) begin
            {scan_up_next, pattern_next} = advance(cur_mode, pattern, scan_up);
        end
    end

    always_ff @(posedge clk_40mhz) begin
        if (accept) begin
            pending_mode <= mode_t'(mode);
        end
    end

    always_ff @(posedge clk_40mhz) begin
        if (!rst_n) begin
            cur_mode    <= MODE_COUNT;
            pattern     <= ALL_OFF;
            scan_up     <= 1'b1;
            prescaler   <= '0;
            pwm_cnt     <= '0;
            step_strobe <= 1'b0;
            led         <= ALL_OFF;
        end else begin
            if (!pause) begin
                prescaler <= wrap ? '0 : prescaler + 1'b1;
            end
            pwm_cnt     <= pwm_cnt + 1'b1;
            step_strobe <= wrap;
            pattern     <= pattern_next;
            scan_up     <= scan_up_next;
            if (load) begin
                cur_mode <= pending_mode;
            end
            led <= pattern & {LED_WIDTH{gate}};
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a 4-cycle step period.
module tb_led_pattern_sequencer;

    logic       clk_40mhz = 1'b0;
    logic       rst_n;
    logic       mode_valid;
    logic       mode_ready;
    logic [1:0] mode;
    logic [3:0] brightness;
    logic       pause;
    logic       step_strobe;
    logic [7:0] led;

    int tests  = 0;
    int failed = 0;

    led_pattern_sequencer #(
        .STEP_PERIOD_CYCLES(4),
        .LED_WIDTH(8),
        .PWM_BITS(4)
    ) dut (
        .clk_40mhz(clk_40mhz),
        .rst_n(rst_n),
        .mode_valid(mode_valid),
        .mode_ready(mode_ready),
        .mode(mode),
        .brightness(brightness),
        .pause(pause),
        .step_strobe(step_strobe),
        .led(led)
    );

    always #5 clk_40mhz = ~clk_40mhz;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Wait (bounded) for the strobe, optionally check its spacing, then check the
    // LED value one cycle later when the registered output has caught up.
    task automatic step(input string tag, input logic [7:0] exp_led, input int exp_gap);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 16) begin
            @(negedge clk_40mhz);
            n++;
            seen = step_strobe;
        end
        check_eq({tag, "_strobe"}, 32'(seen), 32'd1);
        if (exp_gap >= 0) check_eq({tag, "_gap"}, 32'(n), 32'(exp_gap));
        @(negedge clk_40mhz);
        check_eq({tag, "_led"}, 32'(led), 32'(exp_led));
    endtask

    task automatic request_mode(input string tag, input logic [1:0] m);
        check_eq({tag, "_ready_before"}, 32'(mode_ready), 32'd1);
        mode_valid = 1'b1;
        mode       = m;
        @(negedge clk_40mhz);
        mode_valid = 1'b0;
        check_eq({tag, "_ready_after"}, 32'(mode_ready), 32'd0);
    endtask

    task automatic count_lit(input string tag, input logic [3:0] b, input int exp_on);
        int on;
        on = 0;
        brightness = b;
        @(negedge clk_40mhz);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_40mhz);
            if (led != 8'h00) on++;
        end
        check_eq(tag, 32'(on), 32'(exp_on));
    endtask

    initial begin
        int strobes;
        logic [7:0] exp;

        rst_n      = 1'b0;
        mode_valid = 1'b0;
        mode       = 2'd0;
        brightness = 4'hF;
        pause      = 1'b0;

        repeat (3) @(negedge clk_40mhz);
        check_eq("rst_led", 32'(led), 32'h00);
        check_eq("rst_ready", 32'(mode_ready), 32'd1);
        check_eq("rst_strobe", 32'(step_strobe), 32'd0);
        rst_n = 1'b1;

        // COUNT through a full wrap of the 8-bit pattern
        step("count_1", 8'h01, 4);
        for (int k = 2; k <= 256; k++) begin
            exp = 8'(k);
            step("count", exp, 3);
        end
        check_eq("count_wrap", 32'(led), 32'h00);
        strobes = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_40mhz);
            if (step_strobe) strobes++;
        end
        check_eq("count_strobe_duty", 32'(strobes), 32'd4);

        // SCAN bounce with both reversals
        request_mode("scan_req", 2'd1);
        step("scan_load", 8'h01, -1);
        check_eq("scan_ready_back", 32'(mode_ready), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            exp = 8'h01 << i;
            step("scan_up", exp, 3);
        end
        for (int i = 6; i >= 0; i--) begin
            exp = 8'h01 << i;
            step("scan_down", exp, 3);
        end
        step("scan_turn_up", 8'h02, 3);

        // Back to COUNT, then a BLINK request landing on a wrap cycle
        request_mode("count_req", 2'd0);
        step("count_load", 8'h00, -1);
        step("count_next", 8'h01, 3);
        @(negedge clk_40mhz);
        @(negedge clk_40mhz);
        mode_valid = 1'b1;
        mode       = 2'd2;
        @(negedge clk_40mhz);
        check_eq("hs_strobe", 32'(step_strobe), 32'd1);
        check_eq("hs_ready_drop", 32'(mode_ready), 32'd0);
        mode = 2'd3;
        @(negedge clk_40mhz);
        check_eq("hs_old_advance", 32'(led), 32'h02);
        check_eq("hs_ready_held", 32'(mode_ready), 32'd0);
        @(negedge clk_40mhz);
        mode_valid = 1'b0;
        step("blink_load", 8'hFF, -1);
        check_eq("blink_ready_back", 32'(mode_ready), 32'd1);
        step("blink_off", 8'h00, 3);
        step("blink_on", 8'hFF, 3);

        // SHIFT up to 0x08, then pause
        request_mode("shift_req", 2'd3);
        step("shift_load", 8'h01, -1);
        step("shift_1", 8'h02, 3);
        step("shift_2", 8'h04, 3);
        step("shift_3", 8'h08, 3);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_40mhz);
            check_eq("pause_led", 32'(led), 32'h08);
            check_eq("pause_strobe", 32'(step_strobe), 32'd0);
        end
        pause = 1'b0;
        @(negedge clk_40mhz);
        @(negedge clk_40mhz);
        @(negedge clk_40mhz);
        check_eq("resume_strobe", 32'(step_strobe), 32'd1);
        check_eq("resume_led_held", 32'(led), 32'h08);
        @(negedge clk_40mhz);
        check_eq("resume_led", 32'(led), 32'h10);

        // PWM duty over one full PWM period
        count_lit("pwm_b0", 4'd0, 0);
        count_lit("pwm_b4", 4'd4, 4);
        count_lit("pwm_b14", 4'd14, 14);
        count_lit("pwm_b15", 4'd15, 16);

        // Reset while a SHIFT request is pending
        request_mode("rst_pend_req", 2'd3);
        rst_n = 1'b0;
        @(negedge clk_40mhz);
        rst_n = 1'b1;
        check_eq("rst_pend_led", 32'(led), 32'h00);
        check_eq("rst_pend_ready", 32'(mode_ready), 32'd1);
        check_eq("rst_pend_strobe", 32'(step_strobe), 32'd0);
        step("rst_count_1", 8'h01, 4);
        step("rst_count_2", 8'h02, 3);
        step("rst_count_3", 8'h03, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
